// File: rtl/acc_core_p.sv
// Multicycle accumulator core with req/ack instruction and data memory ports.
// A run/stall input, a terminal HALT state and a sticky illegal-opcode flag are included.
//
// state   | meaning
// FETCH   | im_req high, wait for im_ack, latch IR, advance PC
// EXEC    | execute IR; LDM/STM continue in MEM, HALT parks
// MEM     | dm_req high, wait for dm_ack (LDM loads AC and Z)
// HALT    | terminal, no requests, left only through rst
module acc_core_p #(
    parameter int DATA_W = 16,
    parameter int NREG   = 6,
    parameter int PC_W   = 8,
    parameter int DM_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              im_req,
    output logic [PC_W-1:0]   im_addr,
    input  logic [15:0]       im_rdata,
    input  logic              im_ack,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DM_W-1:0]   dm_wdata,
    input  logic [DM_W-1:0]   dm_rdata,
    input  logic              dm_ack,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] ac_out
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_MVA  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_INC  = 4'h7;
    localparam logic [3:0] OP_LDM  = 4'h8;
    localparam logic [3:0] OP_STM  = 4'h9;
    localparam logic [3:0] OP_SDAR = 4'hA;
    localparam logic [3:0] OP_INCD = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_ILL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [1:0]        state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] dar;
    logic              z;
    logic              illegal_q;
    logic [DATA_W-1:0] rf [NREG];

    logic [3:0]        op;
    logic [3:0]        rn;
    logic [7:0]        imm;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign op  = ir[15:12];
    assign rn  = ir[11:8];
    assign imm = ir[7:0];

    // Indices at or above NREG match no register: reads give 0, writes vanish.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rn == 4'(i)) rd = rf[i];
        end
    end

    always_comb begin
        alu = ac;
        case (op)
            OP_LDI:  alu = DATA_W'(imm);
            OP_MVA:  alu = rd;
            OP_ADD:  alu = ac + rd;
            OP_SUB:  alu = ac - rd;
            OP_AND:  alu = ac & rd;
            default: alu = ac;
        endcase
    end

    assign rf_we    = run && (state == S_EXEC) && ((op == OP_MOV) || (op == OP_INC));
    assign rf_wdata = (op == OP_INC) ? rd + DATA_W'(1) : ac;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            ac        <= '0;
            dar       <= '0;
            z         <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (run) begin
            case (state)
                S_FETCH: begin
                    if (im_ack) begin
                        ir    <= im_rdata;
                        pc    <= pc + PC_W'(1);
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (op)
                        OP_LDI, OP_MVA, OP_ADD, OP_SUB, OP_AND: begin
                            ac <= alu;
                            z  <= (alu == '0);
                        end
                        OP_SDAR: dar <= rd;
                        OP_INCD: dar <= dar + DATA_W'(1);
                        OP_JMP:  pc <= PC_W'(imm);
                        OP_JZ:   if (z) pc <= PC_W'(imm);
                        OP_LDM, OP_STM: state <= S_MEM;
                        OP_ILL:  illegal_q <= 1'b1;
                        OP_HALT: state <= S_HALT;
                        default: ;
                    endcase
                    for (int i = 0; i < NREG; i++) begin
                        if (rf_we && (rn == 4'(i))) rf[i] <= rf_wdata;
                    end
                end
                S_MEM: begin
                    if (dm_ack) begin
                        if (op == OP_LDM) begin
                            ac <= DATA_W'(dm_rdata);
                            z  <= (dm_rdata == '0);
                        end
                        state <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests decode straight from state, so a stall holds them unchanged.
    assign im_req   = (state == S_FETCH);
    assign im_addr  = pc;
    assign dm_req   = (state == S_MEM);
    assign dm_we    = (state == S_MEM) && (op == OP_STM);
    assign dm_addr  = dar;
    assign dm_wdata = ac[DM_W-1:0];
    assign halted   = (state == S_HALT);
    assign illegal  = illegal_q;
    assign ac_out   = ac;

endmodule
